// File: rtl/page_out_ctrl_pkg.sv
// Shared constants, FSM state encoding and the output beat layout for page_out_ctrl.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package page_out_ctrl_pkg;

    localparam int NUM_BLOCKS = 16;               // RAM blocks interleaved per 8-byte line
    localparam int BLK_W      = 4;                // log2(NUM_BLOCKS)
    localparam int ADDR_W     = 9;                // line address inside one block
    localparam int LINE_W     = ADDR_W + BLK_W;   // global line index width (13)
    localparam int LEN_W      = LINE_W + 4;       // page length in bytes, 0..65536 (17)
    localparam int LINES_W    = LINE_W + 1;       // line count, 0..8192 (14)
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int CLEAN_CYC  = 514;
    localparam int CLEAN_W    = $clog2(CLEAN_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH,
        ST_CLEAN
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] keep;
        logic [63:0] data;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // Byte enables for the final line: only the low len[2:0] bytes are real.
    function automatic logic [7:0] tail_keep(input logic [2:0] tail);
        logic [7:0] keep;
        if (tail == 3'd0) keep = 8'hff;
        else              keep = 8'hff >> (4'd8 - {1'b0, tail});
        return keep;
    endfunction

endpackage

// File: rtl/page_out_ctrl_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is presented combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; caller must never push when full nor pop when empty.
// Ports: clk, rst (sync, active-high), push_vld/push_dat write side,
//        pop_rdy removes head, head_dat current head, count occupancy.
module sync_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_rdy) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_vld, pop_rdy})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted in.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/page_out_ctrl.sv
// Streams one decompressed page out of 16 interleaved RAM blocks as 64-bit beats, then signals finish.
// Latency: first beat valid 2 cycles after page acceptance (1 cycle RAM read + FIFO push).
// Backpressure: reads are credit-limited by FIFO occupancy + in-flight read; dout_ready low stalls reads.
// Ports: clk, rst (sync, active-high); page_valid_in/page_ready_out/page_len_in/page_last_in page handshake;
//        ram_rd_en_out/ram_rd_addr_out/ram_data_in shared block read port; dout_* output stream;
//        block_out_finish_out/page_finish_out finish pulses; busy_out while not idle.
module page_out_ctrl
    import page_out_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          page_valid_in,
    output logic                          page_ready_out,
    input  logic [LEN_W-1:0]              page_len_in,
    input  logic                          page_last_in,
    output logic                          ram_rd_en_out,
    output logic [ADDR_W-1:0]             ram_rd_addr_out,
    input  logic [NUM_BLOCKS*64-1:0]      ram_data_in,
    output logic                          dout_valid_out,
    input  logic                          dout_ready_in,
    output logic [63:0]                   dout_data_out,
    output logic [7:0]                    dout_keep_out,
    output logic                          dout_last_out,
    output logic                          block_out_finish_out,
    output logic                          page_finish_out,
    output logic                          busy_out
);

    localparam logic [CNT_W:0]     CREDITS    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_CYC - 1);

    state_t               state_q, state_d;
    logic [LINE_W-1:0]    n_q, n_d;
    logic [LINES_W-1:0]   lines_q, lines_d;
    logic [2:0]           tail_q, tail_d;
    logic                 is_last_q, is_last_d;
    logic [CLEAN_W-1:0]   clean_cnt_q, clean_cnt_d;
    logic                 inflight_q, inflight_d;
    logic [BLK_W-1:0]     rd_blk_q, rd_blk_d;
    logic                 rd_last_q, rd_last_d;

    logic [LINES_W-1:0]   page_lines;
    logic                 at_last_line;
    logic                 rd_en;
    logic                 issue_last;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       credit_used;
    logic                 pop;
    beat_t                push_beat;
    beat_t                head_beat;

    // ceil(len/8) without an 18-bit adder: whole lines plus one for a partial tail.
    assign page_lines   = page_len_in[LEN_W-1:3] + LINES_W'(|page_len_in[2:0]);
    assign at_last_line = ({1'b0, n_q} + LINES_W'(1)) == lines_q;
    // Everything that will occupy a FIFO slot: entries already stored plus the read in flight.
    assign credit_used  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        lines_d     = lines_q;
        tail_d      = tail_q;
        is_last_d   = is_last_q;
        clean_cnt_d = clean_cnt_q;
        rd_en       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (page_valid_in) begin
                    lines_d   = page_lines;
                    tail_d    = page_len_in[2:0];
                    is_last_d = page_last_in;
                    n_d       = '0;
                    state_d   = (page_lines == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                if (credit_used < CREDITS) begin
                    rd_en = 1'b1;
                    n_d   = n_q + LINE_W'(1);
                    if (at_last_line) begin
                        issue_last = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_count == '0) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                clean_cnt_d = '0;
                state_d     = is_last_q ? ST_CLEAN : ST_IDLE;
            end
            ST_CLEAN: begin
                if (clean_cnt_q == CLEAN_LAST) state_d = ST_IDLE;
                else                           clean_cnt_d = clean_cnt_q + CLEAN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read pipeline: remember which block and whether it was the final line, one cycle behind rd_en.
    always_comb begin
        inflight_d = rd_en;
        rd_blk_d   = n_q[BLK_W-1:0];
        rd_last_d  = issue_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            lines_q     <= '0;
            tail_q      <= '0;
            is_last_q   <= 1'b0;
            clean_cnt_q <= '0;
            inflight_q  <= 1'b0;
            rd_blk_q    <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            lines_q     <= lines_d;
            tail_q      <= tail_d;
            is_last_q   <= is_last_d;
            clean_cnt_q <= clean_cnt_d;
            inflight_q  <= inflight_d;
            rd_blk_q    <= rd_blk_d;
            rd_last_q   <= rd_last_d;
        end
    end

    always_comb begin
        push_beat.data = ram_data_in[{rd_blk_q, 6'd0} +: 64];
        push_beat.keep = rd_last_q ? tail_keep(tail_q) : 8'hff;
        push_beat.last = rd_last_q;
    end

    assign pop = dout_valid_out && dout_ready_in;

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight_q),
        .push_dat (push_beat),
        .pop_rdy  (pop),
        .head_dat (head_beat),
        .count    (fifo_count)
    );

    // Output fields are zeroed when empty so stale FIFO storage never leaks onto the bus.
    assign dout_valid_out       = (fifo_count != '0);
    assign dout_data_out        = dout_valid_out ? head_beat.data : 64'd0;
    assign dout_keep_out        = dout_valid_out ? head_beat.keep : 8'd0;
    assign dout_last_out        = dout_valid_out && head_beat.last;

    assign ram_rd_en_out        = rd_en;
    assign ram_rd_addr_out      = rd_en ? n_q[LINE_W-1:BLK_W] : '0;
    assign page_ready_out       = (state_q == ST_IDLE);
    assign busy_out             = (state_q != ST_IDLE);
    assign block_out_finish_out = (state_q == ST_FINISH) && !is_last_q;
    assign page_finish_out      = (state_q == ST_FINISH) && is_last_q;

endmodule

// File: tb/tb_page_out_ctrl.sv
// Directed bench for page_out_ctrl with a 1-cycle-latency RAM model and a beat scoreboard.
// Latency: n/a (testbench).
// Backpressure: dout_ready driven high or randomly toggled per step.
module tb_page_out_ctrl;
    import page_out_ctrl_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     page_valid_in = 1'b0;
    logic                     page_ready_out;
    logic [LEN_W-1:0]         page_len_in = '0;
    logic                     page_last_in = 1'b0;
    logic                     ram_rd_en_out;
    logic [ADDR_W-1:0]        ram_rd_addr_out;
    logic [NUM_BLOCKS*64-1:0] ram_data_in;
    logic                     dout_valid_out;
    logic                     dout_ready_in = 1'b0;
    logic [63:0]              dout_data_out;
    logic [7:0]               dout_keep_out;
    logic                     dout_last_out;
    logic                     block_out_finish_out;
    logic                     page_finish_out;
    logic                     busy_out;

    int checks   = 0;
    int failures = 0;

    // Per-page results filled by run_page.
    int beats, bad_beats, stall_err, credit_err, addr_err, rd_cnt;
    int bof_cnt, pf_cnt, clean_low, samples, spam_err;

    always #5 clk = ~clk;

    page_out_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .page_valid_in        (page_valid_in),
        .page_ready_out       (page_ready_out),
        .page_len_in          (page_len_in),
        .page_last_in         (page_last_in),
        .ram_rd_en_out        (ram_rd_en_out),
        .ram_rd_addr_out      (ram_rd_addr_out),
        .ram_data_in          (ram_data_in),
        .dout_valid_out       (dout_valid_out),
        .dout_ready_in        (dout_ready_in),
        .dout_data_out        (dout_data_out),
        .dout_keep_out        (dout_keep_out),
        .dout_last_out        (dout_last_out),
        .block_out_finish_out (block_out_finish_out),
        .page_finish_out      (page_finish_out),
        .busy_out             (busy_out)
    );

    // Distinct content per global line index so misrouted blocks/addresses show up.
    function automatic logic [63:0] line_data(input logic [12:0] n);
        logic [15:0] w;
        w = {3'b000, n};
        return {w, w ^ 16'h0f0f, ~w, w + 16'hc3a5};
    endfunction

    always @(posedge clk) begin
        if (ram_rd_en_out) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                ram_data_in[b*64 +: 64] <= line_data({ram_rd_addr_out, 4'(b)});
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_page(input int len, input bit last, input bit rnd, input bit spam, input int budget);
        int          lines;
        int          r;
        int          issued;
        int          popped;
        int          cyc;
        bit          done;
        bit          fin_seen;
        bit          prev_stall;
        logic [63:0] prev_data;
        logic [7:0]  ek;
        lines = (len + 7) / 8;
        r = len % 8;
        issued = 0; popped = 0; cyc = 0; done = 0; fin_seen = 0; prev_stall = 0; prev_data = '0;
        bad_beats = 0; stall_err = 0; credit_err = 0; addr_err = 0;
        bof_cnt = 0; pf_cnt = 0; clean_low = 0; samples = 0; spam_err = 0;
        page_len_in   = LEN_W'(len);
        page_last_in  = last;
        page_valid_in = 1'b1;
        dout_ready_in = 1'b1;
        check("accept_ready", 64'(page_ready_out), 64'd1);
        step();
        page_valid_in = 1'b0;
        while (!done && cyc < budget) begin
            dout_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spam) begin
                page_valid_in = (cyc >= 1 && cyc <= 4);
                page_len_in   = LEN_W'(8);
                if (page_valid_in && page_ready_out) spam_err++;
            end
            if (ram_rd_en_out) begin
                if (ram_rd_addr_out != 9'(issued >> 4)) addr_err++;
                if (issued - popped >= FIFO_DEPTH) credit_err++;
                issued++;
            end
            if (dout_valid_out) begin
                if (prev_stall && dout_data_out !== prev_data) stall_err++;
                if (dout_ready_in) begin
                    ek = (popped == lines - 1 && r != 0) ? (8'hff >> (8 - r)) : 8'hff;
                    if (dout_data_out !== line_data(13'(popped)) || dout_keep_out !== ek ||
                        dout_last_out !== (popped == lines - 1))
                        bad_beats++;
                    popped++;
                end
                prev_stall = !dout_ready_in;
                prev_data  = dout_data_out;
            end else begin
                prev_stall = 1'b0;
            end
            if (fin_seen && !page_ready_out) clean_low++;
            if (block_out_finish_out || page_finish_out) fin_seen = 1'b1;
            bof_cnt += int'(block_out_finish_out);
            pf_cnt  += int'(page_finish_out);
            samples++;
            if (fin_seen && page_ready_out) done = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        page_valid_in = 1'b0;
        beats  = popped;
        rd_cnt = issued;
        check("page_done_in_budget", 64'(done), 64'd1);
        check("beat_count", 64'(beats), 64'(lines));
        check("rd_en_count", 64'(rd_cnt), 64'(lines));
        check("beat_content", 64'(bad_beats), 64'd0);
        check("addr_sequence", 64'(addr_err), 64'd0);
        check("credit_limit", 64'(credit_err), 64'd0);
        check("block_out_finish_pulses", 64'(bof_cnt), last ? 64'd0 : 64'd1);
        check("page_finish_pulses", 64'(pf_cnt), last ? 64'd1 : 64'd0);
        check("ready_low_after_finish", 64'(clean_low), last ? 64'(CLEAN_CYC) : 64'd0);
    endtask

    initial begin
        int seen;
        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        check("rst_page_ready", 64'(page_ready_out), 64'd1);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_rd_en", 64'(ram_rd_en_out), 64'd0);
        check("rst_rd_addr", 64'(ram_rd_addr_out), 64'd0);
        check("rst_dout_valid", 64'(dout_valid_out), 64'd0);
        check("rst_dout_data", dout_data_out, 64'd0);
        check("rst_finish", 64'({block_out_finish_out, page_finish_out}), 64'd0);
        rst = 1'b0;
        step();

        // Full 64 KiB page, back-to-back.
        run_page(65536, 1'b0, 1'b0, 1'b0, 9000);
        check("full_page_throughput", 64'(samples <= 8200), 64'd1);

        // 13-byte last page: partial keep 8'h1f, then 514-cycle clean.
        run_page(13, 1'b1, 1'b0, 1'b0, 700);

        // Empty page: finish only, IDLE again two cycles after acceptance.
        run_page(0, 1'b0, 1'b0, 1'b0, 50);
        check("len0_samples_to_idle", 64'(samples), 64'd2);

        // Random downstream stalls.
        run_page(64, 1'b0, 1'b1, 1'b0, 400);
        check("stall_data_stable", 64'(stall_err), 64'd0);

        // page_valid while busy must be ignored, then a second page accepted normally.
        run_page(64, 1'b0, 1'b0, 1'b1, 200);
        check("busy_page_ignored", 64'(spam_err), 64'd0);
        run_page(8, 1'b0, 1'b0, 1'b0, 50);

        // Reset in the middle of a read with the output stalled.
        page_len_in   = LEN_W'(512);
        page_last_in  = 1'b0;
        page_valid_in = 1'b1;
        dout_ready_in = 1'b0;
        step();
        page_valid_in = 1'b0;
        repeat (6) step();
        check("mid_busy", 64'(busy_out), 64'd1);
        check("mid_dout_valid", 64'(dout_valid_out), 64'd1);
        rst = 1'b1;
        step();
        check("abort_page_ready", 64'(page_ready_out), 64'd1);
        check("abort_outputs",
              64'({busy_out, ram_rd_en_out, dout_valid_out, dout_last_out,
                   block_out_finish_out, page_finish_out}), 64'd0);
        check("abort_dout_data", dout_data_out, 64'd0);
        check("abort_keep_addr", 64'({dout_keep_out, ram_rd_addr_out}), 64'd0);
        rst = 1'b0;
        dout_ready_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen += int'(block_out_finish_out) + int'(page_finish_out) +
                    int'(dout_valid_out) + int'(ram_rd_en_out);
        end
        check("abort_quiet_after", 64'(seen), 64'd0);

        // Recovery after abort.
        run_page(24, 1'b0, 1'b0, 1'b0, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
